ro_race_arbiter: RTL and testbench

- Race stage of the serialized RO-PUF. Sits downstream of the challenge-selected ring-oscillator pair (mux outputs) and upstream of the response buffer.
- Counts rising edges of two selected ring oscillators in the clk domain. The first to reach THRESHOLD decides one response bit, which is handed to the buffer as a one-cycle valid pulse.
- Includes a timeout path so a stalled oscillator cannot hang the serial loop.

---
 rtl/puf_pkg.sv | 25 ++
 rtl/ro_edge_sync.sv | 26 ++
 rtl/ro_race_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ro_race_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the serialized RO-PUF pipeline: race FSM states and
// default counter sizing used by the race, counter and response-buffer stages.
`timescale 1ns/1ps
package puf_pkg;

   // Race arbiter FSM encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RACE  = 2'd2,
      DONE  = 2'd3
   } race_state_e;

   // Default edge-counter width and winning edge count.
   localparam int unsigned PUF_CNT_W     = 16;
   localparam int unsigned PUF_THRESHOLD = 1024;

   // Decision record produced at the end of a race.
   typedef struct packed {
      logic bit_val;
      logic tie;
      logic timeout;
   } race_result_t;

endpackage : puf_pkg

// File: rtl/ro_edge_sync.sv
// Brings an asynchronous ring-oscillator signal into the clk domain through a
// two-flop synchronizer, then flags each rising edge as a one-cycle pulse.
`timescale 1ns/1ps
module ro_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ro_i,
   output logic edge_o
);

   // sync_q[0..1]: metastability chain; sync_q[2]: previous synchronized value
   logic [2:0] sync_q;

   // Shift the oscillator sample through the synchronizer and history flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], ro_i};
      end
   end

   // Rising edge: synchronized value is high and was low one cycle earlier.
   assign edge_o = sync_q[1] & ~sync_q[2];

endmodule : ro_edge_sync

// File: rtl/ro_race_arbiter.sv
// Race stage of the RO-PUF: counts rising edges of two selected ring
// oscillators and emits one response bit when either reaches THRESHOLD,
// or falls back to comparing partial counts after MAX_CYCLES.
`timescale 1ns/1ps
module ro_race_arbiter
   import puf_pkg::*;
#(
   parameter int unsigned CNT_W      = PUF_CNT_W,
   parameter int unsigned THRESHOLD  = PUF_THRESHOLD,
   parameter int unsigned TMO_W      = 20,
   parameter int unsigned MAX_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ro_a,
   input  logic ro_b,
   output logic bit_out,
   output logic bit_valid,
   output logic busy,
   output logic tie,
   output logic timeout
);

   localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESHOLD);
   localparam logic [TMO_W-1:0] MAX_C = TMO_W'(MAX_CYCLES);

   race_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
   logic [TMO_W-1:0]  cyc_q, cyc_d;
   race_result_t      res_q, res_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic              edge_a_s, edge_b_s;
   logic [CNT_W-1:0]  nxt_a_s, nxt_b_s;
   logic [TMO_W-1:0]  nxt_cyc_s;
   logic              hit_a_s, hit_b_s;

   ro_edge_sync u_sync_a (
      .clk_i  (clk),
      .rst_i  (rst),
      .ro_i   (ro_a),
      .edge_o (edge_a_s)
   );

   ro_edge_sync u_sync_b (
      .clk_i  (clk),
      .rst_i  (rst),
      .ro_i   (ro_b),
      .edge_o (edge_b_s)
   );

   // Candidate counter values for this race cycle, saturating at their limits.
   always_comb begin
      nxt_a_s   = cnt_a_q;
      nxt_b_s   = cnt_b_q;
      nxt_cyc_s = cyc_q;
      if (cnt_a_q >= THR_C) begin
         nxt_a_s = THR_C;
      end else begin
         nxt_a_s = cnt_a_q + {{(CNT_W-1){1'b0}}, edge_a_s};
      end
      if (cnt_b_q >= THR_C) begin
         nxt_b_s = THR_C;
      end else begin
         nxt_b_s = cnt_b_q + {{(CNT_W-1){1'b0}}, edge_b_s};
      end
      if (cyc_q >= MAX_C) begin
         nxt_cyc_s = MAX_C;
      end else begin
         nxt_cyc_s = cyc_q + {{(TMO_W-1){1'b0}}, 1'b1};
      end
   end

   assign hit_a_s = (nxt_a_s == THR_C);
   assign hit_b_s = (nxt_b_s == THR_C);

   // Next-state, counter and decision logic for the race FSM.
   always_comb begin
      state_d = state_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      cyc_d   = cyc_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               res_d   = '{bit_val: 1'b0, tie: 1'b0, timeout: 1'b0};
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            // Edges seen here are dropped: counters restart from zero.
            cnt_a_d = {CNT_W{1'b0}};
            cnt_b_d = {CNT_W{1'b0}};
            cyc_d   = {TMO_W{1'b0}};
            state_d = RACE;
         end
         RACE: begin
            cnt_a_d = nxt_a_s;
            cnt_b_d = nxt_b_s;
            cyc_d   = nxt_cyc_s;
            if (hit_a_s && hit_b_s) begin
               res_d   = '{bit_val: 1'b0, tie: 1'b1, timeout: 1'b0};
               state_d = DONE;
            end else if (hit_a_s) begin
               res_d   = '{bit_val: 1'b1, tie: 1'b0, timeout: 1'b0};
               state_d = DONE;
            end else if (hit_b_s) begin
               res_d   = '{bit_val: 1'b0, tie: 1'b0, timeout: 1'b0};
               state_d = DONE;
            end else if (nxt_cyc_s == MAX_C) begin
               // Stalled race: the oscillator that got further wins, equal gives 0.
               res_d   = '{bit_val: (nxt_a_s > nxt_b_s), tie: 1'b0, timeout: 1'b1};
               state_d = DONE;
            end else begin
               state_d = RACE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output strobes registered from the next state so they align with DONE.
   always_comb begin
      valid_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_a_q <= {CNT_W{1'b0}};
         cnt_b_q <= {CNT_W{1'b0}};
         cyc_q   <= {TMO_W{1'b0}};
         res_q   <= '{bit_val: 1'b0, tie: 1'b0, timeout: 1'b0};
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         cyc_q   <= cyc_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign bit_out   = res_q.bit_val;
   assign tie       = res_q.tie;
   assign timeout   = res_q.timeout;
   assign bit_valid = valid_q;
   assign busy      = busy_q;

endmodule : ro_race_arbiter

// File: tb/tb_ro_race_arbiter.sv
// Self-checking bench for ro_race_arbiter with THRESHOLD=8, MAX_CYCLES=100.
`timescale 1ns/1ps
module tb_ro_race_arbiter;

   typedef struct packed {
      logic b;
      logic t;
      logic o;
   } exp_t;

   typedef struct {
      int   half_a;
      int   half_b;
      bit   tie_m;
      exp_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic ro_a, ro_b;
   logic bit_out, bit_valid, busy, tie, timeout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int cs    = 0;

   exp_t sb[$];

   int   half_a = 20;
   int   half_b = 30;
   logic gen_a  = 1'b0;
   logic gen_b  = 1'b0;
   bit   tie_m  = 1'b0;
   bit   man_m  = 1'b0;
   logic man_a  = 1'b0;
   logic man_b  = 1'b0;

   assign ro_a = man_m ? man_a : gen_a;
   assign ro_b = man_m ? man_b : (tie_m ? gen_a : gen_b);

   ro_race_arbiter #(
      .CNT_W      (16),
      .THRESHOLD  (8),
      .TMO_W      (20),
      .MAX_CYCLES (100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ro_a      (ro_a),
      .ro_b      (ro_b),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .busy      (busy),
      .tie       (tie),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      gen_a = 1'b1;
      #(half_a);
      gen_a = 1'b0;
      #(half_a);
   end

   always begin
      gen_b = 1'b1;
      #(half_b);
      gen_b = 1'b0;
      #(half_b);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard: every bit_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bit_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 32'(bit_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bit_out", 32'(bit_out), 32'(e.b));
            chk("tie", 32'(tie), 32'(e.t));
            chk("timeout", 32'(timeout), 32'(e.o));
         end
      end
   end

   task automatic start_race(input exp_t e);
      @(negedge clk);
      start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cs = cyc;
      chk("busy_after_start", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      bit ok;
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (bit_valid) begin
            lat = cyc - cs + 1;
            ok  = 1'b1;
            break;
         end
      end
      chk("valid_seen", 32'(ok), 32'd1);
   endtask

   task automatic finish_race(input exp_t e);
      int lat;
      wait_valid(lat);
      chk("busy_in_done", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("valid_one_cycle", 32'(bit_valid), 32'd0);
      chk("bit_hold", 32'(bit_out), 32'(e.b));
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {27'd0, bit_out, bit_valid, busy, tie, timeout}, 32'd0);
   endtask

   initial begin
      vec_t tbl[3];
      exp_t e;
      int   lat;

      tbl[0] = '{half_a: 20, half_b: 30, tie_m: 1'b0, exp: '{b: 1'b1, t: 1'b0, o: 1'b0}};
      tbl[1] = '{half_a: 30, half_b: 20, tie_m: 1'b0, exp: '{b: 1'b0, t: 1'b0, o: 1'b0}};
      tbl[2] = '{half_a: 20, half_b: 20, tie_m: 1'b1, exp: '{b: 1'b0, t: 1'b1, o: 1'b0}};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_outputs");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("idle_outputs");

      // table-driven races
      for (int i = 0; i < 3; i++) begin
         half_a = tbl[i].half_a;
         half_b = tbl[i].half_b;
         tie_m  = tbl[i].tie_m;
         repeat (3) @(negedge clk);
         start_race(tbl[i].exp);
         finish_race(tbl[i].exp);
      end
      tie_m = 1'b0;

      // timeout path: ro_a gives 3 edges then stalls, ro_b stuck low
      man_m = 1'b1;
      man_a = 1'b0;
      man_b = 1'b0;
      repeat (3) @(negedge clk);
      e = '{b: 1'b1, t: 1'b0, o: 1'b1};
      start_race(e);
      repeat (3) begin
         @(negedge clk);
         man_a = 1'b1;
         repeat (2) @(negedge clk);
         man_a = 1'b0;
         @(negedge clk);
      end
      wait_valid(lat);
      chk("timeout_latency", 32'(lat), 32'd102);
      @(posedge clk);
      #1;
      chk("busy_after_tmo", 32'(busy), 32'd0);
      chk("timeout_hold", 32'(timeout), 32'd1);
      man_m = 1'b0;

      // start re-pulsed mid-race is ignored; reset mid-race aborts silently
      half_a = 20;
      half_b = 30;
      e = '{b: 1'b1, t: 1'b0, o: 1'b0};
      start_race(e);
      chk("clear_on_start", 32'(timeout), 32'd0);
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid_race", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("abort_async");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk_all_zero("after_abort");

      // fresh race after abort
      start_race(e);
      finish_race(e);

      // eight back-to-back races with alternating winner
      for (int i = 0; i < 8; i++) begin
         half_a = (i % 2 == 0) ? 20 : 30;
         half_b = (i % 2 == 0) ? 30 : 20;
         e = '{b: (i % 2 == 0) ? 1'b1 : 1'b0, t: 1'b0, o: 1'b0};
         start_race(e);
         finish_race(e);
      end

      repeat (5) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ro_race_arbiter
